id_exe_issue: RTL and testbench

Operand-issue stage and ID/EXE pipeline register that produces every input the execute stage consumes: ALU control, immediate, shift select and the two register operands. It resolves operand forwarding from EXE, MEM and WB, detects load-use hazards, inserts bubbles, and honours flush and downstream hold. It sits between the decoder/register file and `execute`.

---
 rtl/id_exe_issue_pkg.sv | 27 ++
 rtl/id_exe_issue_fwd_select.sv | 73 +++++++
 rtl/id_exe_issue.sv | 176 +++++++++++++++++
 tb/tb_id_exe_issue.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_exe_issue_pkg.sv
// rtl/id_exe_issue_pkg.sv - shared widths and constants for the ID/EXE issue stage
//
// Contents:
//   DATA_W       operand/result width (32)
//   REG_W        register index width (5)
//   ZERO_REG     index of the hard-wired zero register
//   issue_ctrl_t the four controls that make an EXE slot live
//   BUBBLE_CTRL  issue_ctrl_t value loaded for a bubble

package id_exe_issue_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic valid;
        logic wreg;
        logic m2reg;
        logic wmem;
    } issue_ctrl_t;

    // A bubble only has to neutralise these four; data fields are don't-care.
    localparam issue_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_exe_issue_fwd_select.sv
// rtl/id_exe_issue_fwd_select.sv - per-source producer match and operand forward select
//
// Optional feature macro: ISSUE_FORWARD_EN (forward muxing enabled when defined).
//
// Ports:
//   src, src_use      source register index and "actually read" flag
//   rf_data           register-file read data for this source
//   exe_rn/exe_wreg/exe_m2reg/exe_alu       EXE producer (exe_wreg pre-qualified by valid)
//   mem_rn/mem_wreg/mem_m2reg/mem_alu/mem_mdata  MEM producer
//   wb_rn/wb_wreg/wb_data                   WB producer
//   data              selected operand
//   exe_load_match    source matches EXE and EXE is a load
//   any_match         source matches any producer stage

module fwd_select
    import id_exe_issue_pkg::*;
(
    input  logic [REG_W-1:0]  src,
    input  logic              src_use,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [REG_W-1:0]  exe_rn,
    input  logic              exe_wreg,
    input  logic              exe_m2reg,
    input  logic [DATA_W-1:0] exe_alu,
    input  logic [REG_W-1:0]  mem_rn,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] mem_mdata,
    input  logic [REG_W-1:0]  wb_rn,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output logic              exe_load_match,
    output logic              any_match
);

    logic live;
    logic exe_hit;
    logic mem_hit;
    logic wb_hit;

    // Register 0 is never a dependency, whoever claims to write it.
    assign live    = src_use && (src != ZERO_REG);
    assign exe_hit = live && exe_wreg && (src == exe_rn);
    assign mem_hit = live && mem_wreg && (src == mem_rn);
    assign wb_hit  = live && wb_wreg  && (src == wb_rn);

    assign exe_load_match = exe_hit && exe_m2reg;
    assign any_match      = exe_hit || mem_hit || wb_hit;

`ifdef ISSUE_FORWARD_EN
    // Youngest producer wins.
    always_comb begin
        data = rf_data;
        if (exe_hit) begin
            data = exe_alu;
        end else if (mem_hit) begin
            data = mem_m2reg ? mem_mdata : mem_alu;
        end else if (wb_hit) begin
            data = wb_data;
        end
    end
`else
    // Without forward paths the top stalls until no producer matches,
    // so the register file is always up to date when we issue.
    assign data = rf_data;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exe_alu, mem_alu, mem_mdata, mem_m2reg, wb_data};
`endif

endmodule

// File: rtl/id_exe_issue.sv
// rtl/id_exe_issue.sv - operand issue, hazard resolution and ID/EXE pipeline register
//
// Optional feature macro: ISSUE_FORWARD_EN
//   defined   : EXE/MEM/WB forwarding; only load-use stalls (one cycle)
//   undefined : operands from register file; stall while any producer matches
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_*                         decoded instruction, register-file data, controls
//   exe_alu                      EXE-stage result (forward source)
//   mem_rn/wreg/m2reg/alu/mdata  MEM-stage destination and data
//   wb_rn/wreg/data              WB-stage destination and data
//   flush                        kill the instruction in ID
//   hold                         downstream stall; freeze this stage
//   exe_*                        registered execute-stage inputs
//   id_stall                     combinational; decoder re-presents next cycle

module id_exe_issue
    import id_exe_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [31:0]       id_qa,
    input  logic [31:0]       id_qb,
    input  logic [4:0]        id_rn,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              id_wmem,
    input  logic [2:0]        id_aluc,
    input  logic              id_aluimm,
    input  logic              id_shift,
    input  logic [31:0]       id_imm,
    input  logic [31:0]       exe_alu,
    input  logic [4:0]        mem_rn,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [31:0]       mem_alu,
    input  logic [31:0]       mem_mdata,
    input  logic [4:0]        wb_rn,
    input  logic              wb_wreg,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    input  logic              hold,
    output logic              exe_valid,
    output logic              exe_wreg,
    output logic              exe_m2reg,
    output logic              exe_wmem,
    output logic [2:0]        exe_aluc,
    output logic              exe_aluimm,
    output logic              exe_shift,
    output logic [31:0]       exe_a,
    output logic [31:0]       exe_b,
    output logic [31:0]       exe_imm,
    output logic [4:0]        exe_rn,
    output logic              id_stall
);

    logic              exe_wreg_live;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              rs_exe_load;
    logic              rt_exe_load;
    logic              rs_any;
    logic              rt_any;
    logic              hazard;
    issue_ctrl_t       next_ctrl;

    // A bubble in EXE may carry stale wreg; only a valid slot produces.
    assign exe_wreg_live = exe_wreg && exe_valid;

    fwd_select u_fwd_rs (
        .src            (id_rs),
        .src_use        (id_use_rs),
        .rf_data        (id_qa),
        .exe_rn         (exe_rn),
        .exe_wreg       (exe_wreg_live),
        .exe_m2reg      (exe_m2reg),
        .exe_alu        (exe_alu),
        .mem_rn         (mem_rn),
        .mem_wreg       (mem_wreg),
        .mem_m2reg      (mem_m2reg),
        .mem_alu        (mem_alu),
        .mem_mdata      (mem_mdata),
        .wb_rn          (wb_rn),
        .wb_wreg        (wb_wreg),
        .wb_data        (wb_data),
        .data           (fwd_a),
        .exe_load_match (rs_exe_load),
        .any_match      (rs_any)
    );

    fwd_select u_fwd_rt (
        .src            (id_rt),
        .src_use        (id_use_rt),
        .rf_data        (id_qb),
        .exe_rn         (exe_rn),
        .exe_wreg       (exe_wreg_live),
        .exe_m2reg      (exe_m2reg),
        .exe_alu        (exe_alu),
        .mem_rn         (mem_rn),
        .mem_wreg       (mem_wreg),
        .mem_m2reg      (mem_m2reg),
        .mem_alu        (mem_alu),
        .mem_mdata      (mem_mdata),
        .wb_rn          (wb_rn),
        .wb_wreg        (wb_wreg),
        .wb_data        (wb_data),
        .data           (fwd_b),
        .exe_load_match (rt_exe_load),
        .any_match      (rt_any)
    );

`ifdef ISSUE_FORWARD_EN
    // Load data is not ready until MEM; everything else is forwardable.
    assign hazard = rs_exe_load || rt_exe_load;

    logic unused_any_match;
    assign unused_any_match = rs_any | rt_any;
`else
    // No bypass: wait for every in-flight producer to retire. The bubble we
    // insert advances the producer each cycle, bounding this to three cycles.
    assign hazard = rs_any || rt_any;

    logic unused_load_match;
    assign unused_load_match = rs_exe_load | rt_exe_load;
`endif

    // hold freezes everything (decoder must wait); flush discards the ID
    // instruction so there is nothing to retry.
    assign id_stall = hold || (!flush && hazard);

    always_comb begin
        next_ctrl.valid = id_valid;
        next_ctrl.wreg  = id_wreg;
        next_ctrl.m2reg = id_m2reg;
        next_ctrl.wmem  = id_wmem;
        if (flush || hazard) begin
            next_ctrl = BUBBLE_CTRL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_valid  <= 1'b0;
            exe_wreg   <= 1'b0;
            exe_m2reg  <= 1'b0;
            exe_wmem   <= 1'b0;
            exe_aluc   <= '0;
            exe_aluimm <= 1'b0;
            exe_shift  <= 1'b0;
            exe_a      <= '0;
            exe_b      <= '0;
            exe_imm    <= '0;
            exe_rn     <= '0;
        end else if (!hold) begin
            // Data fields are loaded even for bubbles; they are dead there.
            exe_valid  <= next_ctrl.valid;
            exe_wreg   <= next_ctrl.wreg;
            exe_m2reg  <= next_ctrl.m2reg;
            exe_wmem   <= next_ctrl.wmem;
            exe_aluc   <= id_aluc;
            exe_aluimm <= id_aluimm;
            exe_shift  <= id_shift;
            exe_a      <= fwd_a;
            exe_b      <= fwd_b;
            exe_imm    <= id_imm;
            exe_rn     <= id_rn;
        end
    end

endmodule

// File: tb/tb_id_exe_issue.sv
// tb/tb_id_exe_issue.sv - self-checking bench for id_exe_issue
module tb_id_exe_issue;

`ifdef ISSUE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_wmem;
    logic id_aluimm, id_shift, mem_wreg, mem_m2reg, wb_wreg, flush, hold;
    logic [4:0]  id_rs, id_rt, id_rn, mem_rn, wb_rn;
    logic [2:0]  id_aluc;
    logic [31:0] id_qa, id_qb, id_imm, exe_alu, mem_alu, mem_mdata, wb_data;
    logic exe_valid, exe_wreg, exe_m2reg, exe_wmem, exe_aluimm, exe_shift, id_stall;
    logic [2:0]  exe_aluc;
    logic [31:0] exe_a, exe_b, exe_imm;
    logic [4:0]  exe_rn;

    id_exe_issue dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_qa(id_qa), .id_qb(id_qb),
        .id_rn(id_rn), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
        .id_aluc(id_aluc), .id_aluimm(id_aluimm), .id_shift(id_shift), .id_imm(id_imm),
        .exe_alu(exe_alu), .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .mem_alu(mem_alu), .mem_mdata(mem_mdata), .wb_rn(wb_rn), .wb_wreg(wb_wreg),
        .wb_data(wb_data), .flush(flush), .hold(hold), .exe_valid(exe_valid),
        .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem),
        .exe_aluc(exe_aluc), .exe_aluimm(exe_aluimm), .exe_shift(exe_shift),
        .exe_a(exe_a), .exe_b(exe_b), .exe_imm(exe_imm), .exe_rn(exe_rn),
        .id_stall(id_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; hold = 0; flush = 0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_qa = 0; id_qb = 0; id_rn = 0; id_wreg = 0; id_m2reg = 0; id_wmem = 0;
        id_aluc = 0; id_aluimm = 0; id_shift = 0; id_imm = 0; exe_alu = 0;
        mem_rn = 0; mem_wreg = 0; mem_m2reg = 0; mem_alu = 0; mem_mdata = 0;
        wb_rn = 0; wb_wreg = 0; wb_data = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Put a producer into EXE: one issue of a write-back instruction with no sources.
    task automatic preload(input logic [4:0] rn, input logic m2reg);
        id_valid = 1; id_rn = rn; id_wreg = 1; id_m2reg = m2reg;
        id_use_rs = 0; id_use_rt = 0;
        tick();
    endtask

    // Downstream pipeline: EXE -> MEM -> WB advance on every edge.
    task automatic step_pipe();
        logic [4:0] e_rn, m_rn;
        logic e_w, e_m, m_w;
        e_rn = exe_rn; e_w = exe_wreg & exe_valid; e_m = exe_m2reg;
        m_rn = mem_rn; m_w = mem_wreg;
        tick();
        mem_rn = e_rn; mem_wreg = e_w; mem_m2reg = e_m;
        wb_rn = m_rn; wb_wreg = m_w;
    endtask

    task automatic run_issue(input string name, input int exp_stalls,
                             input logic [31:0] exp_a, input logic [31:0] exp_b);
        int  stalls;
        bit  issued;
        stalls = 0;
        issued = 0;
        for (int i = 0; i < 8 && !issued; i++) begin
            #1;
            if (id_stall) stalls++;
            step_pipe();
            if (exe_valid) issued = 1;
        end
        chk({name, "_issued"}, 32'(issued), 32'd1);
        chk({name, "_stalls"}, stalls, exp_stalls);
        chk({name, "_a"}, exe_a, exp_a);
        chk({name, "_b"}, exe_b, exp_b);
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [4:0] pre_rn; logic pre_m2reg;
        logic vld; logic [4:0] rs, rt; logic use_rs, use_rt;
        logic [31:0] qa, qb; logic [2:0] aluc; logic [31:0] ealu;
        logic [4:0] mrn; logic mw, mm2; logic [31:0] malu, mdata;
        logic [4:0] wrn; logic ww; logic [31:0] wdata;
        logic x_stall, x_valid; logic [31:0] x_a, x_b;
    } vec_t;

    vec_t vecs[12];

    task automatic fill_vecs();
        vec_t b, v;
        b = '{pre_rn:5'd9, pre_m2reg:1'b0, vld:1'b1, rs:5'd1, rt:5'd2, use_rs:1'b1,
              use_rt:1'b1, qa:32'd5, qb:32'd7, aluc:3'd2, ealu:32'hEE, mrn:5'd0,
              mw:1'b0, mm2:1'b0, malu:32'h0, mdata:32'h0, wrn:5'd0, ww:1'b0,
              wdata:32'h0, x_stall:1'b0, x_valid:1'b1, x_a:32'd5, x_b:32'd7};
        vecs[0] = b;
        v = b; v.rs = 3; v.pre_rn = 3; v.ealu = 32'h10;
        v.x_stall = !FWD; v.x_valid = FWD; v.x_a = 32'h10; vecs[1] = v;
        v.mrn = 3; v.mw = 1; v.malu = 32'h20; vecs[2] = v;
        v = b; v.rt = 4; v.mrn = 4; v.mw = 1; v.mm2 = 1; v.mdata = 32'hAB; v.malu = 32'h20;
        v.x_stall = !FWD; v.x_valid = FWD; v.x_b = 32'hAB; vecs[3] = v;
        v.mm2 = 0; v.x_b = 32'h20; vecs[4] = v;
        v = b; v.rs = 6; v.wrn = 6; v.ww = 1; v.wdata = 32'h66;
        v.x_stall = !FWD; v.x_valid = FWD; v.x_a = 32'h66; vecs[5] = v;
        v = b; v.rs = 5; v.mrn = 5; v.mw = 1; v.malu = 32'h20; v.wrn = 5; v.ww = 1;
        v.wdata = 32'h30; v.x_stall = !FWD; v.x_valid = FWD; v.x_a = 32'h20; vecs[6] = v;
        v = b; v.pre_rn = 0; v.rs = 0; v.ealu = 9; v.qa = 32'h42; v.mrn = 0; v.mw = 1;
        v.x_a = 32'h42; vecs[7] = v;
        v = b; v.pre_rn = 3; v.rs = 3; v.use_rs = 0; v.ealu = 32'h10; vecs[8] = v;
        v = b; v.pre_rn = 4; v.pre_m2reg = 1; v.rt = 4;
        v.x_stall = 1; v.x_valid = 0; vecs[9] = v;
        v = b; v.vld = 0; v.x_valid = 0; vecs[10] = v;
        v = b; v.mrn = 1; v.mw = 0; v.wrn = 2; v.ww = 0; vecs[11] = v;
    endtask

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        do_reset();
        preload(v.pre_rn, v.pre_m2reg);
        id_valid = v.vld; id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs;
        id_use_rt = v.use_rt; id_qa = v.qa; id_qb = v.qb; id_aluc = v.aluc;
        id_rn = 5'd8; id_wreg = 0; id_m2reg = 0;
        exe_alu = v.ealu; mem_rn = v.mrn; mem_wreg = v.mw; mem_m2reg = v.mm2;
        mem_alu = v.malu; mem_mdata = v.mdata; wb_rn = v.wrn; wb_wreg = v.ww;
        wb_data = v.wdata;
        #1;
        chk($sformatf("vec%0d_stall", i), 32'(id_stall), 32'(v.x_stall));
        tick();
        chk($sformatf("vec%0d_valid", i), 32'(exe_valid), 32'(v.x_valid));
        if (v.x_valid) begin
            chk($sformatf("vec%0d_a", i), exe_a, v.x_a);
            chk($sformatf("vec%0d_b", i), exe_b, v.x_b);
            chk($sformatf("vec%0d_aluc", i), 32'(exe_aluc), 32'(v.aluc));
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic valid, wreg, m2reg, wmem, aluimm, shift;
        logic [2:0] aluc;
        logic [31:0] a, b, imm;
        logic [4:0] rn;
        bit bubble;
    } mstate_t;

    mstate_t m;

    // Look through producers oldest-first so the youngest match overwrites.
    task automatic resolve(input logic [4:0] idx, input logic use_it, input logic [31:0] rf,
                           output logic [31:0] val, output bit any_hit, output bit exe_load);
        logic [4:0]  p_rn[3];
        bit          p_w[3];
        logic [31:0] p_d[3];
        p_rn[0] = m.rn;   p_w[0] = m.valid & m.wreg; p_d[0] = exe_alu;
        p_rn[1] = mem_rn; p_w[1] = mem_wreg;         p_d[1] = mem_m2reg ? mem_mdata : mem_alu;
        p_rn[2] = wb_rn;  p_w[2] = wb_wreg;          p_d[2] = wb_data;
        val = rf; any_hit = 0; exe_load = 0;
        if (use_it && idx != 0) begin
            for (int k = 2; k >= 0; k--) begin
                if (p_w[k] && p_rn[k] == idx) begin
                    any_hit = 1;
                    if (FWD) val = p_d[k];
                    if (k == 0) exe_load = m.m2reg;
                end
            end
        end
    endtask

    task automatic random_phase(input int cycles);
        mstate_t nm;
        logic [31:0] va, vb;
        bit ha, hb, la, lb, hz;
        m = '{default: 0};
        for (int c = 0; c < cycles; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            hold = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            id_qa = $urandom; id_qb = $urandom; id_imm = $urandom;
            id_rn = 5'($urandom_range(0, 3)); id_wreg = 1'($urandom);
            id_m2reg = 1'($urandom); id_wmem = 1'($urandom);
            id_aluc = 3'($urandom); id_aluimm = 1'($urandom); id_shift = 1'($urandom);
            exe_alu = $urandom;
            mem_rn = 5'($urandom_range(0, 3)); mem_wreg = 1'($urandom);
            mem_m2reg = 1'($urandom); mem_alu = $urandom; mem_mdata = $urandom;
            wb_rn = 5'($urandom_range(0, 3)); wb_wreg = 1'($urandom); wb_data = $urandom;
            #1;
            resolve(id_rs, id_use_rs, id_qa, va, ha, la);
            resolve(id_rt, id_use_rt, id_qb, vb, hb, lb);
            hz = FWD ? (la | lb) : (ha | hb);
            if (!rst) chk("rand_stall", 32'(id_stall), 32'(hold | (!flush & hz)));
            nm = m;
            if (rst) begin
                nm = '{default: 0};
            end else if (!hold) begin
                nm.aluc = id_aluc; nm.aluimm = id_aluimm; nm.shift = id_shift;
                nm.a = va; nm.b = vb; nm.imm = id_imm; nm.rn = id_rn;
                if (flush || hz) begin
                    nm.valid = 0; nm.wreg = 0; nm.m2reg = 0; nm.wmem = 0; nm.bubble = 1;
                end else begin
                    nm.valid = id_valid; nm.wreg = id_wreg; nm.m2reg = id_m2reg;
                    nm.wmem = id_wmem; nm.bubble = 0;
                end
            end
            tick();
            m = nm;
            chk("rand_valid", 32'(exe_valid), 32'(m.valid));
            chk("rand_wreg", 32'(exe_wreg), 32'(m.wreg));
            chk("rand_m2reg", 32'(exe_m2reg), 32'(m.m2reg));
            chk("rand_wmem", 32'(exe_wmem), 32'(m.wmem));
            if (!m.bubble) begin
                chk("rand_a", exe_a, m.a);
                chk("rand_b", exe_b, m.b);
                chk("rand_imm", exe_imm, m.imm);
                chk("rand_rn", 32'(exe_rn), 32'(m.rn));
                chk("rand_aluc", 32'(exe_aluc), 32'(m.aluc));
                chk("rand_aluimm", 32'(exe_aluimm), 32'(m.aluimm));
                chk("rand_shift", 32'(exe_shift), 32'(m.shift));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(exe_valid), 0);
        chk({tag, "_wreg"}, 32'(exe_wreg), 0);
        chk({tag, "_m2reg"}, 32'(exe_m2reg), 0);
        chk({tag, "_wmem"}, 32'(exe_wmem), 0);
        chk({tag, "_ctl"}, {exe_aluc, exe_aluimm, exe_shift, exe_rn}, 0);
        chk({tag, "_a"}, exe_a, 0);
        chk({tag, "_b"}, exe_b, 0);
        chk({tag, "_imm"}, exe_imm, 0);
        chk({tag, "_stall"}, 32'(id_stall), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        quiet();
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk_all_zero("reset");

        fill_vecs();
        for (int i = 0; i < 12; i++) apply_vec(i);

        // Load-use: one bubble then MEM data (forwarding), or drain to WB retirement.
        do_reset();
        mem_mdata = 32'hAB; mem_alu = 32'h20; wb_data = 32'h30;
        preload(5'd4, 1'b1);
        mem_rn = 0; mem_wreg = 0; wb_rn = 0; wb_wreg = 0;
        id_rn = 7; id_m2reg = 0; id_rt = 4; id_use_rt = 1; id_qb = 32'h55;
        run_issue("loaduse", FWD ? 1 : 3, 32'h0, FWD ? 32'hAB : 32'h55);

        // Non-load EXE producer.
        do_reset();
        mem_mdata = 32'hAB; mem_alu = 32'h20; wb_data = 32'h30;
        preload(5'd6, 1'b0);
        mem_rn = 0; mem_wreg = 0; wb_rn = 0; wb_wreg = 0;
        exe_alu = 32'h60; id_rn = 7; id_rs = 6; id_use_rs = 1; id_qa = 32'h11;
        run_issue("exe_nonload", FWD ? 0 : 3, FWD ? 32'h60 : 32'h11, 32'h0);

        // WB-only producer.
        do_reset();
        wb_rn = 6; wb_wreg = 1; wb_data = 32'h30;
        id_valid = 1; id_rn = 7; id_rs = 6; id_use_rs = 1; id_qa = 32'h11;
        run_issue("wb_only", FWD ? 0 : 1, FWD ? 32'h30 : 32'h11, 32'h0);

        // Hold freezes, flush bubbles, flush beats hazard, hold masks hazard, reset clears.
        do_reset();
        id_valid = 1; id_qa = 5; id_qb = 7; id_aluc = 2; id_rn = 1; id_wreg = 1;
        tick();
        chk("plain_a", exe_a, 5);
        chk("plain_b", exe_b, 7);
        chk("plain_aluc", 32'(exe_aluc), 2);
        chk("plain_valid", 32'(exe_valid), 1);
        id_qa = 32'h99; id_aluc = 5; hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_stall", 32'(id_stall), 1);
            tick();
            chk("hold_a", exe_a, 5);
            chk("hold_aluc", 32'(exe_aluc), 2);
            chk("hold_valid", 32'(exe_valid), 1);
        end
        hold = 0; flush = 1;
        #1;
        chk("flush_stall", 32'(id_stall), 0);
        tick();
        chk("flush_valid", 32'(exe_valid), 0);
        chk("flush_wreg", 32'(exe_wreg), 0);
        flush = 0;
        preload(5'd4, 1'b1);
        id_m2reg = 0; id_rn = 9; id_rt = 4; id_use_rt = 1; flush = 1;
        #1;
        chk("flush_hz_stall", 32'(id_stall), 0);
        tick();
        chk("flush_hz_valid", 32'(exe_valid), 0);
        flush = 0;
        preload(5'd4, 1'b1);
        id_m2reg = 0; id_rn = 9; id_rt = 4; id_use_rt = 1; hold = 1;
        #1;
        chk("hold_hz_stall", 32'(id_stall), 1);
        tick();
        chk("hold_hz_m2reg", 32'(exe_m2reg), 1);
        chk("hold_hz_valid", 32'(exe_valid), 1);
        hold = 0;
        #1;
        chk("hold_drop_stall", 32'(id_stall), 1);
        rst = 1;
        tick();
        quiet();
        #1;
        chk_all_zero("midstall_reset");

        do_reset();
        random_phase(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
